// File: rtl/basilisk_result_arbiter.sv
// Merges mult/add/misc FPU results into one writeback stream via per-source 1-entry skid buffers and round-robin grants.
// Latency 2 cycles (registered output) or 1 (combinational output); optional stall counters under BASILISK_RESULT_ARBITER_STATS_EN.

package basilisk_result_pkg;
  typedef struct packed {
    logic [4:0]  dest_reg;
    logic [31:0] data;
    logic [4:0]  fflags;
  } basilisk_result_t;
endpackage

module basilisk_result_arbiter
  import basilisk_result_pkg::*;
#(
  parameter int OUTPUT_REGISTER_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult_result_command_vld_i,
  output logic             mult_result_command_rdy_o,
  input  basilisk_result_t mult_result_command_dat_i,
  input  logic             add_result_command_vld_i,
  output logic             add_result_command_rdy_o,
  input  basilisk_result_t add_result_command_dat_i,
  input  logic             misc_result_command_vld_i,
  output logic             misc_result_command_rdy_o,
  input  basilisk_result_t misc_result_command_dat_i,
  output logic             writeback_command_vld_o,
  input  logic             writeback_command_rdy_i,
  output basilisk_result_t writeback_command_dat_o
`ifdef BASILISK_RESULT_ARBITER_STATS_EN
  ,
  output logic [31:0]      stat_mult_stall_o,
  output logic [31:0]      stat_add_stall_o,
  output logic [31:0]      stat_misc_stall_o
`endif
);

  localparam int N = 3;
  localparam bit OUT_REG = (OUTPUT_REGISTER_MODE != 0);

  logic [N-1:0]     in_vld;
  logic [N-1:0]     in_rdy;
  basilisk_result_t in_dat [N];

  logic [N-1:0]     buf_vld_q, buf_vld_d;
  basilisk_result_t buf_dat_q [N];
  basilisk_result_t buf_dat_d [N];
  logic [1:0]       ptr_q, ptr_d;
  logic             hold_vld_q, hold_vld_d;
  logic [1:0]       hold_idx_q, hold_idx_d;
  logic             out_vld_q, out_vld_d;
  basilisk_result_t out_dat_q, out_dat_d;

  logic             rr_vld;
  logic [1:0]       rr_idx;
  logic [1:0]       sel_idx;
  basilisk_result_t sel_dat;
  logic             out_can_take;
  logic             grant_any;
  logic [N-1:0]     grant;

  assign in_vld    = {misc_result_command_vld_i, add_result_command_vld_i, mult_result_command_vld_i};
  assign in_dat[0] = mult_result_command_dat_i;
  assign in_dat[1] = add_result_command_dat_i;
  assign in_dat[2] = misc_result_command_dat_i;

  assign mult_result_command_rdy_o = in_rdy[0];
  assign add_result_command_rdy_o  = in_rdy[1];
  assign misc_result_command_rdy_o = in_rdy[2];

  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] ofs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // Scan from lowest to highest priority so the highest-priority full buffer wins.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (buf_vld_q[wrap_add(ptr_q, 2'(k))]) begin
        rr_vld = 1'b1;
        rr_idx = wrap_add(ptr_q, 2'(k));
      end
    end
  end

  // A stalled combinational output keeps showing the same buffer even if a
  // higher-priority buffer fills meanwhile, so the payload stays stable.
  assign sel_idx      = (!OUT_REG && hold_vld_q) ? hold_idx_q : rr_idx;
  assign sel_dat      = buf_dat_q[sel_idx];
  assign out_can_take = OUT_REG ? (!out_vld_q || writeback_command_rdy_i) : writeback_command_rdy_i;
  assign grant_any    = rr_vld && out_can_take;

  always_comb begin
    grant = '0;
    if (grant_any) grant[sel_idx] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_rdy[i]    = !buf_vld_q[i] || grant[i];
      buf_vld_d[i] = buf_vld_q[i];
      buf_dat_d[i] = buf_dat_q[i];
      if (grant[i]) buf_vld_d[i] = 1'b0;
      if (in_vld[i] && in_rdy[i]) begin
        buf_vld_d[i] = 1'b1;
        buf_dat_d[i] = in_dat[i];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    hold_vld_d = !OUT_REG && rr_vld && !writeback_command_rdy_i;
    hold_idx_d = sel_idx;
    if (grant_any) ptr_d = wrap_add(sel_idx, 2'd1);
    if (out_vld_q && writeback_command_rdy_i) out_vld_d = 1'b0;
    if (grant_any) begin
      out_vld_d = 1'b1;
      out_dat_d = sel_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q  <= '0;
      for (int i = 0; i < N; i++) buf_dat_q[i] <= '0;
      ptr_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_idx_q <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      for (int i = 0; i < N; i++) buf_dat_q[i] <= buf_dat_d[i];
      ptr_q      <= ptr_d;
      hold_vld_q <= hold_vld_d;
      hold_idx_q <= hold_idx_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
    end
  end

  assign writeback_command_vld_o = OUT_REG ? out_vld_q : rr_vld;
  assign writeback_command_dat_o = OUT_REG ? out_dat_q : (rr_vld ? sel_dat : '0);

`ifdef BASILISK_RESULT_ARBITER_STATS_EN
  logic [31:0] stat_q [N];
  logic [31:0] stat_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      stat_d[i] = stat_q[i];
      if (in_vld[i] && !in_rdy[i] && (stat_q[i] != 32'hFFFF_FFFF)) stat_d[i] = stat_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stat_mult_stall_o = stat_q[0];
  assign stat_add_stall_o  = stat_q[1];
  assign stat_misc_stall_o = stat_q[2];
`else
  // Stall counters are compiled out; the stall condition has no other consumer.
`endif

  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  wb_stable_a: assert property (@(posedge clk) disable iff (rst)
    writeback_command_vld_o && !writeback_command_rdy_i |=>
    writeback_command_vld_o && $stable(writeback_command_dat_o));

endmodule

// File: tb/tb_basilisk_result_arbiter.sv
// Bench for basilisk_result_arbiter: one instance per output mode, shared scoreboard and stream engine.
module tb_basilisk_result_arbiter;
  import basilisk_result_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             src_vld [2][3];
  logic             src_rdy [2][3];
  basilisk_result_t src_dat [2][3];
  logic             wb_vld [2];
  logic             wb_rdy [2];
  basilisk_result_t wb_dat [2];
  logic [31:0]      stat_w [2][3];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    basilisk_result_arbiter #(.OUTPUT_REGISTER_MODE(m)) u_dut (
      .clk                       (clk),
      .rst                       (rst),
      .mult_result_command_vld_i (src_vld[m][0]),
      .mult_result_command_rdy_o (src_rdy[m][0]),
      .mult_result_command_dat_i (src_dat[m][0]),
      .add_result_command_vld_i  (src_vld[m][1]),
      .add_result_command_rdy_o  (src_rdy[m][1]),
      .add_result_command_dat_i  (src_dat[m][1]),
      .misc_result_command_vld_i (src_vld[m][2]),
      .misc_result_command_rdy_o (src_rdy[m][2]),
      .misc_result_command_dat_i (src_dat[m][2]),
      .writeback_command_vld_o   (wb_vld[m]),
      .writeback_command_rdy_i   (wb_rdy[m]),
      .writeback_command_dat_o   (wb_dat[m])
`ifdef BASILISK_RESULT_ARBITER_STATS_EN
      ,
      .stat_mult_stall_o         (stat_w[m][0]),
      .stat_add_stall_o          (stat_w[m][1]),
      .stat_misc_stall_o         (stat_w[m][2])
`endif
    );
  end

  typedef struct {
    logic [2:0] mask;
    int         n;
    int         order [3];
  } rec_t;
  rec_t tbl [10];

  basilisk_result_t ord_q [2][$];
  basilisk_result_t src_q [6][$];
  basilisk_result_t fixed_dat [2][3];
  basilisk_result_t prev_dat [2];
  int  budget [2][3];
  int  prob [2][3];
  int  seq [2][3];
  int  wb_prob [2];
  bit  taken [2][3];
  int  acc_cnt [2][3];
  int  acc_cyc [2][3];
  int  out_cnt [2][3];
  int  out_total [2];
  int  rise_cyc [2];
  bit  stall_prev [2];
  bit  prev_vld [2];
  bit  prev_xfer [2];
  int  last_src [2];
  int  alt_viol [2];
  int  bursts [2];
  bit  alt_on = 1'b0;
  bit  ordered = 1'b1;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stream engine: drives sources and writeback ready just after each rising edge.
  initial begin
    basilisk_result_t d;
    for (int m = 0; m < 2; m++) begin
      wb_rdy[m] = 1'b1;
      wb_prob[m] = 100;
      for (int i = 0; i < 3; i++) begin
        src_vld[m][i] = 1'b0;
        src_dat[m][i] = '0;
        budget[m][i] = 0;
        prob[m][i] = 100;
        seq[m][i] = 0;
      end
    end
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 3; i++) begin
          if (rst) begin
            src_vld[m][i] = 1'b0;
          end else begin
            if (src_vld[m][i] && taken[m][i]) src_vld[m][i] = 1'b0;
            if (!src_vld[m][i] && budget[m][i] > 0 && int'($urandom_range(99)) < prob[m][i]) begin
              if (ordered) begin
                d = fixed_dat[m][i];
              end else begin
                d.dest_reg = 5'($urandom);
                d.data     = {2'(i), 1'(m), 29'(seq[m][i])};
                d.fflags   = 5'($urandom);
                src_q[m*3+i].push_back(d);
              end
              seq[m][i]++;
              budget[m][i]--;
              src_vld[m][i] = 1'b1;
              src_dat[m][i] = d;
            end
          end
        end
        wb_rdy[m] = int'($urandom_range(99)) < wb_prob[m];
      end
    end
  end

  // Monitor: inputs are stable from just after posedge until the next posedge.
  always @(negedge clk) begin
    basilisk_result_t e;
    int s;
    bit ok;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < 3; i++) taken[m][i] = 1'b0;
        stall_prev[m] = 1'b0;
        prev_vld[m] = 1'b0;
        prev_xfer[m] = 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          taken[m][i] = src_vld[m][i] && src_rdy[m][i];
          if (taken[m][i]) begin
            acc_cnt[m][i]++;
            acc_cyc[m][i] = cyc;
          end
        end
        if (wb_vld[m] && !prev_vld[m]) rise_cyc[m] = cyc;
        if (stall_prev[m])
          chk($sformatf("hold_m%0d", m), {21'd0, wb_vld[m], wb_dat[m]}, {21'd0, 1'b1, prev_dat[m]});
        if (wb_vld[m] && wb_rdy[m]) begin
          out_total[m]++;
          if (ordered) begin
            ok = ord_q[m].size() != 0;
            chk($sformatf("expected_beat_m%0d", m), 64'(ok), 64'd1);
            if (ok) begin
              e = ord_q[m].pop_front();
              chk($sformatf("order_m%0d", m), 64'(wb_dat[m]), 64'(e));
            end
          end else begin
            s = int'(wb_dat[m].data[31:30]);
            ok = 1'b0;
            if (s < 3) ok = src_q[m*3+s].size() != 0;
            chk($sformatf("known_src_m%0d", m), 64'(ok), 64'd1);
            if (ok) begin
              e = src_q[m*3+s].pop_front();
              chk($sformatf("fifo_m%0d_s%0d", m, s), 64'(wb_dat[m]), 64'(e));
              out_cnt[m][s]++;
              if (alt_on) begin
                if (!prev_xfer[m]) bursts[m]++;
                if (last_src[m] == s) alt_viol[m]++;
                last_src[m] = s;
              end
            end
          end
        end
        prev_xfer[m]  = wb_vld[m] && wb_rdy[m];
        stall_prev[m] = wb_vld[m] && !wb_rdy[m];
        prev_vld[m]   = wb_vld[m];
        prev_dat[m]   = wb_dat[m];
      end
    end
  end

  function automatic bit idle();
    bit r = 1'b1;
    for (int m = 0; m < 2; m++) begin
      if (wb_vld[m] || ord_q[m].size() != 0) r = 1'b0;
      for (int i = 0; i < 3; i++)
        if (budget[m][i] != 0 || src_vld[m][i] || src_q[m*3+i].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_drain(input string tag, input int maxc);
    int k = 0;
    while (k < maxc && !idle()) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("drain_%s", tag), 64'(idle()), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      ord_q[m].delete();
      for (int i = 0; i < 3; i++) begin
        budget[m][i] = 0;
        src_q[m*3+i].delete();
      end
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_vld_m%0d", tag, m), 64'(wb_vld[m]), 64'd0);
      chk($sformatf("%s_dat_m%0d", tag, m), 64'(wb_dat[m]), 64'd0);
      chk($sformatf("%s_rdy_m%0d", tag, m),
          {61'd0, src_rdy[m][2], src_rdy[m][1], src_rdy[m][0]}, 64'd7);
    end
  endtask

  task automatic set_rec(input int r, input logic [2:0] mask, input int n,
                         input int o0, input int o1, input int o2);
    tbl[r].mask = mask;
    tbl[r].n = n;
    tbl[r].order[0] = o0;
    tbl[r].order[1] = o1;
    tbl[r].order[2] = o2;
  endtask

  task automatic run_rec(input int r);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 3; i++) begin
        fixed_dat[m][i].dest_reg = 5'(r + i);
        fixed_dat[m][i].data     = 32'(r * 256 + i + 1);
        fixed_dat[m][i].fflags   = 5'(i);
      end
      for (int j = 0; j < tbl[r].n; j++) ord_q[m].push_back(fixed_dat[m][tbl[r].order[j]]);
      for (int i = 0; i < 3; i++) if (tbl[r].mask[i]) budget[m][i] = 1;
    end
    wait_drain($sformatf("rec%0d", r), 50);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_acc [2][3];
    int snap_out [2][3];
    int snap_tot [2];

    // Pointer evolves across records starting from 0 after reset.
    set_rec(0, 3'b111, 3, 0, 1, 2);
    set_rec(1, 3'b001, 1, 0, 0, 0);
    set_rec(2, 3'b111, 3, 1, 2, 0);
    set_rec(3, 3'b101, 2, 2, 0, 0);
    set_rec(4, 3'b011, 2, 1, 0, 0);
    set_rec(5, 3'b110, 2, 1, 2, 0);
    set_rec(6, 3'b100, 1, 2, 0, 0);
    set_rec(7, 3'b011, 2, 0, 1, 0);
    set_rec(8, 3'b111, 3, 2, 0, 1);
    set_rec(9, 3'b010, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_idle_outputs("reset");

    // Single mult result: latency and single beat.
    for (int m = 0; m < 2; m++) begin
      snap_tot[m] = out_total[m];
      fixed_dat[m][0].dest_reg = 5'd5;
      fixed_dat[m][0].data = 32'h3F80_0000;
      fixed_dat[m][0].fflags = 5'd0;
      ord_q[m].push_back(fixed_dat[m][0]);
      budget[m][0] = 1;
    end
    wait_drain("single", 50);
    repeat (5) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("latency_m%0d", m), 64'(rise_cyc[m] - acc_cyc[m][0]), 64'(m + 1));
      chk($sformatf("single_beats_m%0d", m), 64'(out_total[m] - snap_tot[m]), 64'd1);
    end

    do_reset();
    for (int r = 0; r < 10; r++) run_rec(r);

    // Output stalled for 10 cycles with mult and add streaming.
    do_reset();
    ordered = 1'b0;
    for (int m = 0; m < 2; m++) begin
      wb_prob[m] = 0;
      for (int i = 0; i < 3; i++) begin
        snap_acc[m][i] = acc_cnt[m][i];
        snap_out[m][i] = out_cnt[m][i];
      end
      budget[m][0] = 4;
      budget[m][1] = 4;
    end
    repeat (10) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("stall_mult_acc_m%0d", m), 64'(acc_cnt[m][0] - snap_acc[m][0]), 64'(m == 1 ? 2 : 1));
      chk($sformatf("stall_add_acc_m%0d", m), 64'(acc_cnt[m][1] - snap_acc[m][1]), 64'd1);
      chk($sformatf("stall_wb_vld_m%0d", m), 64'(wb_vld[m]), 64'd1);
      wb_prob[m] = 100;
    end
    wait_drain("stall", 100);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("stall_mult_out_m%0d", m), 64'(out_cnt[m][0] - snap_out[m][0]), 64'd4);
      chk($sformatf("stall_add_out_m%0d", m), 64'(out_cnt[m][1] - snap_out[m][1]), 64'd4);
    end

    // Reset with buffers full and output valid; stale beats must vanish.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      wb_prob[m] = 0;
      budget[m][0] = 3;
      budget[m][1] = 3;
    end
    repeat (6) @(negedge clk);
    for (int m = 0; m < 2; m++) chk($sformatf("pre_rst_vld_m%0d", m), 64'(wb_vld[m]), 64'd1);
    do_reset();
    for (int m = 0; m < 2; m++) wb_prob[m] = 100;
    check_idle_outputs("midrst");
    ordered = 1'b1;
    run_rec(0);

    // Two continuously valid sources alternate at one result per cycle.
    do_reset();
    ordered = 1'b0;
    for (int m = 0; m < 2; m++) begin
      last_src[m] = 1;
      alt_viol[m] = 0;
      bursts[m] = 0;
      for (int i = 0; i < 3; i++) snap_out[m][i] = out_cnt[m][i];
    end
    alt_on = 1'b1;
    for (int m = 0; m < 2; m++) begin
      budget[m][0] = 8;
      budget[m][1] = 8;
    end
    wait_drain("alt", 100);
    alt_on = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("alt_viol_m%0d", m), 64'(alt_viol[m]), 64'd0);
      chk($sformatf("alt_bursts_m%0d", m), 64'(bursts[m]), 64'd1);
      chk($sformatf("alt_mult_m%0d", m), 64'(out_cnt[m][0] - snap_out[m][0]), 64'd8);
      chk($sformatf("alt_add_m%0d", m), 64'(out_cnt[m][1] - snap_out[m][1]), 64'd8);
    end

    // Random valid/ready traffic against the per-source scoreboard.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      wb_prob[m] = 65;
      for (int i = 0; i < 3; i++) begin
        snap_out[m][i] = out_cnt[m][i];
        prob[m][i] = int'($urandom_range(90, 30));
        budget[m][i] = 1700;
      end
    end
    wait_drain("random", 40000);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++)
        chk($sformatf("rand_count_m%0d_s%0d", m, i), 64'(out_cnt[m][i] - snap_out[m][i]), 64'd1700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
